// File: rtl/if_id_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_id_fetch_queue
//
// Small FIFO between instruction fetch (IF) and decode (ID). Each fetched
// {PC, instruction} pair is captured and the oldest entry is presented to
// decode. Hazard-unit stalls hold the head entry without losing fetched words.
// A taken branch/jump (Flush) discards every queued word and the same-cycle
// input, so wrong-path instructions never reach decode.
//
// Ports:
//   clk         rising-edge clock
//   ReSet       asynchronous, active-high reset
//   InValid     IF presents a fetched word this cycle
//   InPC        PC of the fetched word
//   InInstr     fetched instruction word
//   InReady     queue can accept a word this cycle (Count < DEPTH)
//   Stall       decode cannot consume the head entry this cycle
//   Flush       discard all entries and the same-cycle input
//   OutValid    head entry valid (Count != 0)
//   OutPC       PC of the head entry, 0 when empty
//   OutPcPlus4  OutPC + 4, 0 when empty
//   OutInstr    head instruction, NOP_INSTR when empty
//   Count       number of valid entries, 0..DEPTH
//   FlushDrops  saturating count of valid entries discarded by Flush
// ---------------------------------------------------------------------------
module if_id_fetch_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned PTR_W     = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             ReSet,
    input  logic             InValid,
    input  logic [31:0]      InPC,
    input  logic [31:0]      InInstr,
    output logic             InReady,
    input  logic             Stall,
    input  logic             Flush,
    output logic             OutValid,
    output logic [31:0]      OutPC,
    output logic [31:0]      OutPcPlus4,
    output logic [31:0]      OutInstr,
    output logic [PTR_W:0]   Count,
    output logic [7:0]       FlushDrops
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Entry storage: written on push only, never cleared by reset.
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count_q;
    logic [7:0]       drops_q;

    logic             push;
    logic             pop;
    logic [8:0]       drop_sum;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // InReady is derived from the registered count only, so a pop in the
    // same cycle as a full queue does not open the input until next cycle.
    always_comb begin
        InReady  = (count_q < DEPTH_C);
        OutValid = (count_q != '0);
        push     = InValid & InReady & ~Flush;
        pop      = OutValid & ~Stall & ~Flush;
        drop_sum = {1'b0, drops_q} + 9'(count_q);
    end

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]    <= InPC;
            instr_mem[wptr] <= InInstr;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk or posedge ReSet) begin
        if (ReSet) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (Flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flush drop statistics (saturating at 255)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge ReSet) begin
        if (ReSet) begin
            drops_q <= '0;
        end else if (Flush) begin
            drops_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Decode-side outputs: combinational from the head entry
    // ------------------------------------------------------------------
    always_comb begin
        OutPC      = '0;
        OutPcPlus4 = '0;
        OutInstr   = NOP_INSTR;
        if (OutValid) begin
            OutPC      = pc_mem[rptr];
            OutPcPlus4 = pc_mem[rptr] + 32'd4;
            OutInstr   = instr_mem[rptr];
        end
    end

    assign Count      = count_q;
    assign FlushDrops = drops_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
module tb_if_id_fetch_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PTR_W = 1;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic            clk;
    logic            ReSet;
    logic            InValid;
    logic [31:0]     InPC;
    logic [31:0]     InInstr;
    logic            InReady;
    logic            Stall;
    logic            Flush;
    logic            OutValid;
    logic [31:0]     OutPC;
    logic [31:0]     OutPcPlus4;
    logic [31:0]     OutInstr;
    logic [PTR_W:0]  Count;
    logic [7:0]      FlushDrops;

    if_id_fetch_queue #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W),
        .NOP_INSTR(NOP)
    ) dut (
        .clk       (clk),
        .ReSet     (ReSet),
        .InValid   (InValid),
        .InPC      (InPC),
        .InInstr   (InInstr),
        .InReady   (InReady),
        .Stall     (Stall),
        .Flush     (Flush),
        .OutValid  (OutValid),
        .OutPC     (OutPC),
        .OutPcPlus4(OutPcPlus4),
        .OutInstr  (OutInstr),
        .Count     (Count),
        .FlushDrops(FlushDrops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      expq[$];
    int unsigned mdrops;
    bit          accepted;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: samples on the falling edge. The reference state
    // represents the queue after the previous rising edge; inputs seen here
    // decide what the next rising edge does to it.
    always @(negedge clk) begin
        bit     mpush;
        bit     mpop;
        entry_t e;
        accepted = 1'b0;
        if (ReSet) begin
            expq.delete();
            mdrops = 0;
        end else begin
            chk("Count",      32'(Count),      32'(expq.size()));
            chk("InReady",    32'(InReady),    32'(expq.size() < DEPTH));
            chk("OutValid",   32'(OutValid),   32'(expq.size() != 0));
            chk("FlushDrops", 32'(FlushDrops), mdrops);
            if (expq.size() != 0) begin
                e = expq[0];
                chk("OutPC",      OutPC,      e.pc);
                chk("OutPcPlus4", OutPcPlus4, e.pc + 32'd4);
                chk("OutInstr",   OutInstr,   e.instr);
            end else begin
                chk("OutPC empty",    OutPC,      32'h0);
                chk("OutPcP4 empty",  OutPcPlus4, 32'h0);
                chk("OutInstr empty", OutInstr,   NOP);
            end
            mpush = InValid && (expq.size() < DEPTH) && !Flush;
            mpop  = (expq.size() != 0) && !Stall && !Flush;
            if (Flush) begin
                mdrops = mdrops + expq.size();
                if (mdrops > 255) mdrops = 255;
                expq.delete();
            end else begin
                if (mpop) void'(expq.pop_front());
                if (mpush) expq.push_back('{pc: InPC, instr: InInstr});
            end
            accepted = mpush;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted (bounded).
    task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic stall);
        bit done;
        done    = 1'b0;
        InValid = 1'b1;
        InPC    = pc;
        InInstr = instr;
        Stall   = stall;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (accepted) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL send timeout: pc %h not accepted, expected acceptance", pc);
        end
        InValid = 1'b0;
    endtask

    initial begin
        bit done;
        n_vec   = 0;
        n_bad   = 0;
        mdrops  = 0;
        ReSet   = 1'b1;
        InValid = 1'b0;
        InPC    = '0;
        InInstr = '0;
        Stall   = 1'b0;
        Flush   = 1'b0;
        cyc();
        cyc();
        ReSet = 1'b0;
        cyc();

        // Asynchronous reset mid-cycle with a word queued.
        send(32'h0000_2000, 32'h1111_1111, 1'b1);
        @(posedge clk);
        #3;
        ReSet = 1'b1;
        #1;
        chk("rst OutValid",   32'(OutValid),   32'h0);
        chk("rst OutInstr",   OutInstr,        32'h0);
        chk("rst Count",      32'(Count),      32'h0);
        chk("rst InReady",    32'(InReady),    32'h1);
        chk("rst FlushDrops", 32'(FlushDrops), 32'h0);
        cyc();
        ReSet = 1'b0;
        Stall = 1'b0;
        cyc();

        // Single word: visible right after the accepting edge, gone one edge later.
        send(32'h0000_3000, 32'h2008_0005, 1'b0);
        chk("single OutValid",   32'(OutValid), 32'h1);
        chk("single OutPC",      OutPC,         32'h0000_3000);
        chk("single OutPcPlus4", OutPcPlus4,    32'h0000_3004);
        chk("single OutInstr",   OutInstr,      32'h2008_0005);
        cyc();
        chk("single drained",    32'(Count),    32'h0);

        // Fill under stall, then hold a third word until space opens.
        send(32'h0000_3000, 32'hA000_0000, 1'b1);
        send(32'h0000_3004, 32'hA000_0004, 1'b1);
        InValid = 1'b1;
        InPC    = 32'h0000_3008;
        InInstr = 32'hA000_0008;
        chk("full Count",   32'(Count),   32'h2);
        chk("full InReady", 32'(InReady), 32'h0);
        cyc();
        Stall = 1'b0;
        chk("release InReady", 32'(InReady), 32'h0);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (accepted) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL hold timeout: 3008 not accepted, expected acceptance");
        end
        InValid = 1'b0;
        repeat (4) cyc();

        // Flush with a full queue and a same-cycle input word.
        send(32'h0000_3100, 32'hB000_0000, 1'b1);
        send(32'h0000_3104, 32'hB000_0004, 1'b1);
        Flush   = 1'b1;
        InValid = 1'b1;
        InPC    = 32'h0000_3010;
        InInstr = 32'hB000_0010;
        cyc();
        Flush   = 1'b0;
        InValid = 1'b0;
        Stall   = 1'b0;
        chk("flush Count",      32'(Count),      32'h0);
        chk("flush OutValid",   32'(OutValid),   32'h0);
        chk("flush FlushDrops", 32'(FlushDrops), 32'h2);
        repeat (2) cyc();
        chk("flush no 3010",    OutPC,           32'h0);

        // Streaming with simultaneous push/pop across pointer wrap.
        for (int unsigned k = 0; k < 10; k++) begin
            send(32'h0000_3000 + 32'(4 * k), 32'hC000_0000 + 32'(k), 1'b0);
            chk("stream head", OutPC, 32'h0000_3000 + 32'(4 * k));
        end
        repeat (3) cyc();

        // Saturation of FlushDrops, ending with back-to-back flushes.
        for (int unsigned k = 0; k < 130; k++) begin
            send(32'h0000_4000, 32'hD000_0000, 1'b1);
            send(32'h0000_4004, 32'hD000_0004, 1'b1);
            Flush = 1'b1;
            cyc();
            Flush = 1'b0;
            Stall = 1'b0;
        end
        chk("sat FlushDrops", 32'(FlushDrops), 32'hFF);
        send(32'h0000_4008, 32'hD000_0008, 1'b1);
        Flush = 1'b1;
        cyc();
        cyc();
        Flush = 1'b0;
        Stall = 1'b0;
        chk("sat hold FlushDrops", 32'(FlushDrops), 32'hFF);
        chk("sat Count",           32'(Count),      32'h0);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Sits between the PC unit / instruction memory (IF) and the decoder (ID) of the pipeline.
- Captures each fetched {PC, instruction} pair into a small FIFO.
- Presents the oldest entry to decode, absorbing hazard-unit stalls without losing fetched words.
- Discards all queued words on a taken branch/jump (Flush) so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 2, number of queue entries; power of two, 2..8.
- PTR_W, 1, pointer width = log2(DEPTH).
- NOP_INSTR, 32'h0000_0000, instruction word driven on OutInstr when the queue is empty.

Ports:
- clk  input  1  rising-edge clock.
- ReSet  input  1  asynchronous, active-high reset.
- InValid  input  1  IF presents a valid fetched word this cycle.
- InPC  input  32  PC of the fetched word.
- InInstr  input  32  fetched instruction word.
- InReady  output  1  queue can accept a word this cycle; equals (Count < DEPTH).
- Stall  input  1  decode cannot consume this cycle (hazard unit).
- Flush  input  1  taken branch/jump; discard all entries and the same-cycle input.
- OutValid  output  1  head entry valid; equals (Count != 0).
- OutPC  output  32  PC of the head entry; 0 when empty.
- OutPcPlus4  output  32  OutPC + 4 (mod 2^32); 0 when empty.
- OutInstr  output  32  head instruction; NOP_INSTR when empty.
- Count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- FlushDrops  output  8  saturating count of valid entries discarded by Flush.

Behaviour:
- Reset (async, ReSet=1):
  - Count=0, read/write pointers=0, FlushDrops=0.
  - OutValid=0, OutPC=0, OutPcPlus4=0, OutInstr=NOP_INSTR, InReady=1.
  - Entry storage is not cleared.
  - Reset mid-operation discards all entries immediately, asynchronously.
- Push: push = InValid & InReady & !Flush. On a push, write {InPC, InInstr} at wptr and increment wptr (wraps modulo DEPTH).
- Pop: pop = OutValid & !Stall & !Flush. On a pop, increment rptr (wraps modulo DEPTH).
- Count update: Count += push - pop. Simultaneous push and pop leave Count unchanged.
- Outputs: OutValid, OutPC, OutPcPlus4 and OutInstr are combinational from the head entry (rptr) and Count. Storage is registered.
- Latency: a word pushed at edge N is visible on the outputs after edge N when the queue was empty. There is no combinational pass-through from In* to Out*.
- Full (Count=DEPTH):
  - InReady=0; IF must hold InValid/InPC/InInstr.
  - A pop in the same cycle does not make InReady high that cycle. InReady rises the next cycle.
- Empty (Count=0):
  - OutValid=0; Stall is ignored.
  - Decode sees NOP_INSTR with PC 0.
- Flush (highest priority among synchronous events):
  - At the next edge: Count=0, rptr=wptr=0.
  - Any same-cycle InValid word is dropped, with no push.
  - No pop is counted.
  - FlushDrops += Count (old value), saturating at 255.
  - Flush while empty changes nothing except pointer reset.
- Flush with Stall: Flush wins; the queue empties.
- Consecutive Flush cycles: each empties the queue. FlushDrops adds only the entries present.
- Pointer wrap: after the pointer reaches DEPTH-1, the next increment yields 0. FIFO order is preserved across the wrap.

Test Plan:
- Reset then idle: assert ReSet mid-cycle → outputs immediately OutValid=0, OutInstr=0, Count=0, InReady=1, FlushDrops=0.
- Single word: InValid=1, InPC=0x3000, InInstr=0x2008_0005 for one cycle, Stall=0 → next cycle OutValid=1, OutPC=0x3000, OutPcPlus4=0x3004, OutInstr=0x2008_0005; the following cycle Count=0.
- Fill under stall: Stall=1, push PCs 0x3000 and 0x3004 → Count=2, InReady=0. Hold 0x3008 on InValid. Release Stall → decode sees 0x3000, then 0x3004, then 0x3008 in order, and 0x3008 is accepted only after InReady returns to 1.
- Flush with a full queue: Count=2, Flush=1 with InValid=1, InPC=0x3010 → next cycle Count=0, OutValid=0, FlushDrops=2. PC 0x3010 never appears on OutPC.
- Wrap-around and simultaneous push/pop: stream 10 words, PC 0x3000..0x3024, with Stall=0 → each appears exactly once, in order, one cycle after push. Count stays ≤1 and pointers wrap without corruption.
- Saturation: 130 flushes each with Count=2 → FlushDrops=255 and stays 255.
